// File: rtl/ets_pkg.sv
// Shared types and constants for the ETS sweep controller.
package ets_pkg;

    localparam int TAP_W_DEFAULT  = 8;
    localparam int DATA_W_DEFAULT = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        RUN     = 3'd2,
        RELEASE = 3'd3,
        ERROR   = 3'd4
    } state_t;

    // Bits needed to hold the values 0..max_count (never less than one).
    function automatic int count_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/ets_wait_timer.sv
// Loadable down-counter with a zero flag. It stops at zero and holds there
// until the next load.
module ets_wait_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    // Load takes priority; otherwise count down while enabled until zero.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: clocked state uses non-blocking (<=) so every register updates from pre-edge values.
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ets_sweep_ctrl.sv
// ETS sweep controller: steps the delay tap from tap_first to tap_last and
// runs one accumulator start/done handshake per tap, writing each result out.
// Optional RUN watchdog: define ETS_SWEEP_TIMEOUT_EN.
module ets_sweep_ctrl
    import ets_pkg::*;
#(
    parameter int TAP_W          = TAP_W_DEFAULT,
    parameter int DATA_W         = DATA_W_DEFAULT,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2**24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sweep_start,
    input  logic              sweep_abort,
    input  logic [TAP_W-1:0]  tap_first,
    input  logic [TAP_W-1:0]  tap_last,
    output logic [TAP_W-1:0]  delay_tap,
    output logic              acc_start,
    input  logic              acc_done,
    input  logic [DATA_W-1:0] acc_data,
    output logic              res_we,
    output logic [TAP_W-1:0]  res_addr,
    output logic [DATA_W-1:0] res_data,
    output logic              sweep_busy,
    output logic              sweep_done,
    output logic              sweep_err
);

    // Reject timing parameters that would break the handshake spacing.
    if (SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("ets_sweep_ctrl: SETTLE_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    // The settle timer is loaded with N-1 so SETTLE lasts exactly N cycles.
    localparam int                  SETTLE_W    = count_width(SETTLE_CYCLES);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [TAP_W-1:0]    TAP_ONE     = TAP_W'(1);

    state_t           state;
    logic [TAP_W-1:0] tap_first_q;
    logic [TAP_W-1:0] tap_last_q;
    logic             inverted_q;
    logic             abort_pending;
    logic             last_step;
    logic             settle_load;
    logic             settle_zero;

    assign last_step   = (delay_tap == tap_last_q) || inverted_q || abort_pending;
    assign settle_load = ((state == IDLE) && sweep_start) ||
                         ((state == RELEASE) && !acc_done && !last_step);

    ets_wait_timer #(.W(SETTLE_W)) u_settle_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (settle_load),
        .load_value (SETTLE_LOAD),
        .en         (state == SETTLE),
        .zero       (settle_zero)
    );

`ifdef ETS_SWEEP_TIMEOUT_EN
    // Watchdog armed as RUN is entered; it reaches zero on RUN cycle TIMEOUT_CYCLES.
    localparam int                   TIMEOUT_W    = count_width(TIMEOUT_CYCLES);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LOAD = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic timeout_zero;

    ets_wait_timer #(.W(TIMEOUT_W)) u_timeout_timer (
        .clk        (clk),
        .reset      (reset),
        .load       ((state == SETTLE) && settle_zero),
        .load_value (TIMEOUT_LOAD),
        .en         (state == RUN),
        .zero       (timeout_zero)
    );
`else
    assign sweep_err = 1'b0;
`endif

    // Sweep sequencer: all outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            tap_first_q   <= '0;
            tap_last_q    <= '0;
            inverted_q    <= 1'b0;
            abort_pending <= 1'b0;
            delay_tap     <= '0;
            acc_start     <= 1'b0;
            res_we        <= 1'b0;
            res_addr      <= '0;
            res_data      <= '0;
            sweep_busy    <= 1'b0;
            sweep_done    <= 1'b0;
`ifdef ETS_SWEEP_TIMEOUT_EN
            sweep_err     <= 1'b0;
`endif
        end else begin
            // NOTE: strobes default low here so any path that does not raise them clears them.
            res_we     <= 1'b0;
            sweep_done <= 1'b0;

            // An abort is remembered and acted on at the next step boundary.
            if ((state != IDLE) && sweep_abort) begin
                abort_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (sweep_start) begin
                        tap_first_q   <= tap_first;
                        tap_last_q    <= tap_last;
                        inverted_q    <= (tap_last < tap_first);
                        delay_tap     <= tap_first;
                        abort_pending <= 1'b0;
                        sweep_busy    <= 1'b1;
                        state         <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (settle_zero) begin
                        acc_start <= 1'b1;
                        state     <= RUN;
                    end
                end

                RUN: begin
                    if (acc_done) begin
                        res_we    <= 1'b1;
                        res_data  <= acc_data;
                        res_addr  <= delay_tap - tap_first_q;
                        acc_start <= 1'b0;
                        state     <= RELEASE;
                    end
`ifdef ETS_SWEEP_TIMEOUT_EN
                    else if (timeout_zero) begin
                        // The request cannot be withdrawn, so acc_start and busy stay high.
                        sweep_err  <= 1'b1;
                        sweep_done <= 1'b1;
                        state      <= ERROR;
                    end
`endif
                end

                RELEASE: begin
                    if (!acc_done) begin
                        if (last_step) begin
                            sweep_busy    <= 1'b0;
                            sweep_done    <= 1'b1;
                            abort_pending <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            delay_tap <= delay_tap + TAP_ONE;
                            state     <= SETTLE;
                        end
                    end
                end

`ifdef ETS_SWEEP_TIMEOUT_EN
                ERROR: begin
                    state <= ERROR;
                end
`endif

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ets_sweep_ctrl.sv
// Directed testbench for ets_sweep_ctrl with a behavioural accumulator.
// The watchdog section runs only when ETS_SWEEP_TIMEOUT_EN is defined.
module tb_ets_sweep_ctrl;

    localparam int TAP_W   = 8;
    localparam int DATA_W  = 32;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 100;

    logic              clk = 1'b0;
    logic              reset;
    logic              sweep_start;
    logic              sweep_abort;
    logic [TAP_W-1:0]  tap_first;
    logic [TAP_W-1:0]  tap_last;
    logic [TAP_W-1:0]  delay_tap;
    logic              acc_start;
    logic              acc_done;
    logic [DATA_W-1:0] acc_data;
    logic              res_we;
    logic [TAP_W-1:0]  res_addr;
    logic [DATA_W-1:0] res_data;
    logic              sweep_busy;
    logic              sweep_done;
    logic              sweep_err;

    int errors = 0;
    int checks = 0;

    // Accumulator model knobs.
    int acc_lat   = 2;
    int acc_hold  = 0;
    bit acc_stuck = 1'b0;

    // Monitor log.
    int               cyc       = 0;
    int               done_cnt  = 0;
    int               proto_bad = 0;
    int               run_cyc   = 0;
    int               err_cyc   = 0;
    logic [TAP_W-1:0] wr_addr[$];
    logic [DATA_W-1:0] wr_data[$];
    int               settle_q[$];

    ets_sweep_ctrl #(
        .TAP_W          (TAP_W),
        .DATA_W         (DATA_W),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sweep_start (sweep_start),
        .sweep_abort (sweep_abort),
        .tap_first   (tap_first),
        .tap_last    (tap_last),
        .delay_tap   (delay_tap),
        .acc_start   (acc_start),
        .acc_done    (acc_done),
        .acc_data    (acc_data),
        .res_we      (res_we),
        .res_addr    (res_addr),
        .res_data    (res_data),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .sweep_err   (sweep_err)
    );

    initial forever #5 clk = ~clk;

    // Hard stop if the run somehow never reaches its summary.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "watchdog expired");
    end

    // Accumulator: answers acc_start after acc_lat cycles with tap*10, and
    // keeps acc_done high for acc_hold cycles after acc_start falls.
    initial begin : acc_model
        int cnt;
        int hold_cnt;
        cnt      = 0;
        hold_cnt = 0;
        acc_done = 1'b0;
        acc_data = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                acc_done = 1'b0;
                cnt      = 0;
                hold_cnt = 0;
            end else if (!acc_done) begin
                if (acc_start && !acc_stuck) begin
                    cnt++;
                    if (cnt >= acc_lat) begin
                        acc_done = 1'b1;
                        acc_data = 32'(delay_tap) * 32'd10;
                        cnt      = 0;
                    end
                end else begin
                    cnt = 0;
                end
            end else if (!acc_start) begin
                if (hold_cnt >= acc_hold) begin
                    acc_done = 1'b0;
                    acc_data = '0;
                    hold_cnt = 0;
                end else begin
                    hold_cnt++;
                end
            end
        end
    end

    // Monitor: samples just after each rising edge and logs writes, done
    // pulses, settle spacing and handshake-order violations.
    initial begin : monitor
        logic             prev_start;
        logic             prev_busy;
        logic             prev_err;
        logic [TAP_W-1:0] prev_tap;
        int               last_change;
        prev_start  = 1'b0;
        prev_busy   = 1'b0;
        prev_err    = 1'b0;
        prev_tap    = '0;
        last_change = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!reset) begin
                if (res_we) begin
                    wr_addr.push_back(res_addr);
                    wr_data.push_back(res_data);
                end
                if (sweep_done) done_cnt++;
                if ((delay_tap != prev_tap) || (sweep_busy && !prev_busy)) begin
                    last_change = cyc;
                    if (acc_done && (delay_tap != prev_tap)) proto_bad++;
                end
                if (acc_start && !prev_start) begin
                    settle_q.push_back(cyc - last_change);
                    run_cyc = cyc;
                    if (acc_done) proto_bad++;
                end
                if (sweep_err && !prev_err) err_cyc = cyc;
            end
            prev_start = acc_start;
            prev_busy  = sweep_busy;
            prev_err   = sweep_err;
            prev_tap   = delay_tap;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        settle_q.delete();
        done_cnt  = 0;
        proto_bad = 0;
    endtask

    // NOTE: bench inputs are driven with blocking assignments on the falling edge, away from the DUT's sampling edge.
    task automatic start_sweep(input logic [TAP_W-1:0] first, input logic [TAP_W-1:0] last,
                               input logic with_abort);
        @(negedge clk);
        tap_first   = first;
        tap_last    = last;
        sweep_start = 1'b1;
        sweep_abort = with_abort;
        @(negedge clk);
        sweep_start = 1'b0;
        sweep_abort = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (sweep_busy && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_timeout"}, 64'(n >= budget), 0);
    endtask

    task automatic wait_run(input string tag, input logic [TAP_W-1:0] tap, input int budget);
        int n;
        n = 0;
        while (!(acc_start && (delay_tap == tap)) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_run_timeout"}, 64'(n >= budget), 0);
    endtask

    // Expect n writes at addresses 0..n-1 carrying (first+i)*10.
    task automatic check_writes(input string tag, input int first, input int n);
        check({tag, "_wr_count"}, wr_addr.size(), n);
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_addr[i], i);
            check($sformatf("%s_data%0d", tag, i), wr_data[i], (first + i) * 10);
        end
    endtask

    initial begin
        reset       = 1'b1;
        sweep_start = 1'b0;
        sweep_abort = 1'b0;
        tap_first   = '0;
        tap_last    = '0;
        repeat (3) @(negedge clk);

        // Reset values.
        check("rst_acc_start", acc_start, 0);
        check("rst_busy", sweep_busy, 0);
        check("rst_done", sweep_done, 0);
        check("rst_err", sweep_err, 0);
        check("rst_tap", delay_tap, 0);
        check("rst_we", res_we, 0);
        check("rst_addr", res_addr, 0);
        check("rst_data", res_data, 0);
        reset = 1'b0;

        // Basic sweep 3..6: four writes 30..60, settle spacing 4 cycles.
        clear_log();
        acc_lat  = 2;
        acc_hold = 0;
        start_sweep(8'd3, 8'd6, 1'b0);
        wait_idle("t1", 500);
        check_writes("t1", 3, 4);
        check("t1_done_pulses", done_cnt, 1);
        check("t1_settle_count", settle_q.size(), 4);
        for (int i = 0; i < settle_q.size(); i++) begin
            check($sformatf("t1_settle%0d", i), settle_q[i], 4);
        end
        check("t1_proto", proto_bad, 0);
        check("t1_busy", sweep_busy, 0);
        check("t1_final_tap", delay_tap, 6);

        // acc_done held 5 cycles after acc_start falls: no early advance or re-request.
        clear_log();
        acc_hold = 5;
        start_sweep(8'd0, 8'd2, 1'b0);
        wait_idle("t2", 500);
        check_writes("t2", 0, 3);
        check("t2_proto", proto_bad, 0);
        check("t2_done_pulses", done_cnt, 1);
        check("t2_settle_first", (settle_q.size() > 1) ? settle_q[1] : -1, 4);

        // Abort during RUN at tap 2 of 0..9: tap-2 result kept, then stop.
        clear_log();
        acc_hold = 0;
        acc_lat  = 3;
        start_sweep(8'd0, 8'd9, 1'b0);
        wait_run("t3", 8'd2, 500);
        sweep_abort = 1'b1;
        @(negedge clk);
        sweep_abort = 1'b0;
        wait_idle("t3", 500);
        check_writes("t3", 0, 3);
        check("t3_done_pulses", done_cnt, 1);
        check("t3_busy", sweep_busy, 0);
        check("t3_final_tap", delay_tap, 2);

        // Inverted range 10..2: a single step at tap 10.
        clear_log();
        acc_lat = 2;
        start_sweep(8'd10, 8'd2, 1'b0);
        wait_idle("t4", 500);
        check_writes("t4", 10, 1);
        check("t4_final_tap", delay_tap, 10);
        check("t4_done_pulses", done_cnt, 1);

        // sweep_start mid-sweep is ignored.
        clear_log();
        start_sweep(8'd5, 8'd7, 1'b0);
        repeat (10) @(negedge clk);
        tap_first   = 8'd0;
        tap_last    = 8'd1;
        sweep_start = 1'b1;
        @(negedge clk);
        sweep_start = 1'b0;
        wait_idle("t5", 500);
        check_writes("t5", 5, 3);
        check("t5_done_pulses", done_cnt, 1);

        // Start and abort in the same IDLE cycle: the abort is dropped.
        clear_log();
        start_sweep(8'd4, 8'd5, 1'b1);
        wait_idle("t6", 500);
        check_writes("t6", 4, 2);

        // Top of the tap range: ends at 255 without wrapping.
        clear_log();
        start_sweep(8'd254, 8'd255, 1'b0);
        wait_idle("t7", 500);
        check_writes("t7", 254, 2);
        check("t7_final_tap", delay_tap, 255);
        check("t7_busy", sweep_busy, 0);

        // Reset during RUN, then a clean sweep afterwards.
        clear_log();
        acc_lat = 3;
        start_sweep(8'd0, 8'd3, 1'b0);
        wait_run("t8", 8'd0, 500);
        reset = 1'b1;
        #1;
        check("t8_rst_acc_start", acc_start, 0);
        check("t8_rst_busy", sweep_busy, 0);
        check("t8_rst_tap", delay_tap, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_log();
        acc_lat = 2;
        start_sweep(8'd1, 8'd2, 1'b0);
        wait_idle("t8", 500);
        check_writes("t8", 1, 2);
        check("t8_done_pulses", done_cnt, 1);

`ifdef ETS_SWEEP_TIMEOUT_EN
        // acc_done stuck low: error after exactly TIMEOUT RUN cycles.
        begin
            int n;
            clear_log();
            acc_stuck = 1'b1;
            start_sweep(8'd0, 8'd0, 1'b0);
            n = 0;
            while (!sweep_err && (n < 400)) begin
                @(negedge clk);
                n++;
            end
            check("to_wait_timeout", 64'(n >= 400), 0);
            check("to_latency", err_cyc - run_cyc, TIMEOUT);
            check("to_done_pulses", done_cnt, 1);
            check("to_no_write", wr_addr.size(), 0);
            repeat (10) @(negedge clk);
            check("to_err_sticky", sweep_err, 1);
            check("to_acc_start_held", acc_start, 1);
            check("to_busy_held", sweep_busy, 1);
            check("to_done_once", done_cnt, 1);
            reset = 1'b1;
            #1;
            check("to_rst_err", sweep_err, 0);
            check("to_rst_acc_start", acc_start, 0);
            repeat (2) @(negedge clk);
            reset     = 1'b0;
            acc_stuck = 1'b0;
        end
`else
        check("no_timeout_err", sweep_err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
